// File: rtl/uart_rx_framer.sv
// uart_rx_framer
// 8N1 serial receiver with 16x oversampling. Each bit is decided by a 2-of-3 vote.
// It rejects false starts and flags framing errors. A held-low line (break) is
// reported once, and the receiver then waits for a full idle bit before it
// re-arms for the next frame.
module uart_rx_framer #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_serial,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       frame_err,
   output logic       break_det,
   output logic       rx_active
);

   // Clocks per oversample tick, rounded to nearest (27 at defaults).
   localparam int DIV   = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [OS_W-1:0]  IDX_S0   = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  IDX_S1   = OS_W'(OVERSAMPLE / 2);
   localparam logic [OS_W-1:0]  IDX_VOTE = OS_W'(OVERSAMPLE / 2 + 1);
   localparam logic [OS_W-1:0]  IDX_LAST = OS_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } state_t;

   // 2-of-3 majority of the three mid-bit samples.
   function automatic logic maj3(input logic [2:0] v);
      maj3 = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   state_t            state_r;
   state_t            state_nx;
   logic              sync1_r;
   logic              sync2_r;
   logic              prev_r;
   logic [DIV_W-1:0]  div_cnt_r;
   logic [OS_W-1:0]   samp_idx_r;
   logic [OS_W-1:0]   idle_cnt_r;
   logic [2:0]        bit_cnt_r;
   logic [1:0]        samp_r;
   logic [7:0]        shift_r;
   logic [7:0]        rx_data_r;
   logic              rx_ready_r;
   logic              frame_err_r;
   logic              break_det_r;
   logic              rx_active_r;

   logic              rx_s;
   logic              fall_s;
   logic              tick_s;
   logic              vote_tick_s;
   logic              end_tick_s;
   logic              vote_s;
   logic              shift_en_s;
   logic              bit_inc_s;
   logic              load_s;
   logic              ferr_s;
   logic              brk_s;

   assign rx_s        = sync2_r;
   assign fall_s      = prev_r & ~rx_s;
   assign tick_s      = (div_cnt_r == DIV_LAST);
   assign vote_tick_s = tick_s & (samp_idx_r == IDX_VOTE);
   assign end_tick_s  = tick_s & (samp_idx_r == IDX_LAST);
   assign vote_s      = maj3({rx_s, samp_r});

   assign rx_data   = rx_data_r;
   assign rx_ready  = rx_ready_r;
   assign frame_err = frame_err_r;
   assign break_det = break_det_r;
   assign rx_active = rx_active_r;

   // Two-flop synchronizer for the line, plus the previous sample for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
      end else begin
         sync1_r <= rx_serial;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Tick divider and in-bit sample index. Both are held at zero while idle, so START always begins aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_r  <= '0;
         samp_idx_r <= '0;
      end else if (state_r == ST_IDLE) begin
         div_cnt_r  <= '0;
         samp_idx_r <= '0;
      end else if (tick_s) begin
         div_cnt_r  <= '0;
         samp_idx_r <= (samp_idx_r == IDX_LAST) ? '0 : samp_idx_r + OS_W'(1);
      end else begin
         div_cnt_r  <= div_cnt_r + DIV_W'(1);
      end
   end

   // Capture the two early mid-bit samples. The third sample is the live value at vote time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_r <= 2'b11;
      end else if (tick_s && (samp_idx_r == IDX_S0)) begin
         samp_r[0] <= rx_s;
      end else if (tick_s && (samp_idx_r == IDX_S1)) begin
         samp_r[1] <= rx_s;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      state_nx   = state_r;
      shift_en_s = 1'b0;
      bit_inc_s  = 1'b0;
      load_s     = 1'b0;
      ferr_s     = 1'b0;
      brk_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fall_s) begin
               state_nx = ST_START;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_START: begin
            if (vote_tick_s && vote_s) begin
               state_nx = ST_IDLE;
            end else if (end_tick_s) begin
               state_nx = ST_DATA;
            end else begin
               state_nx = ST_START;
            end
         end
         ST_DATA: begin
            shift_en_s = vote_tick_s;
            if (end_tick_s) begin
               if (bit_cnt_r == 3'd7) begin
                  state_nx = ST_STOP;
               end else begin
                  bit_inc_s = 1'b1;
               end
            end else begin
               state_nx = ST_DATA;
            end
         end
         ST_STOP: begin
            // Decide at mid-stop so a back-to-back start edge is not missed.
            if (vote_tick_s) begin
               if (vote_s) begin
                  load_s   = 1'b1;
                  state_nx = ST_IDLE;
               end else begin
                  ferr_s   = 1'b1;
                  brk_s    = (shift_r == 8'h00);
                  state_nx = ST_WAIT_IDLE;
               end
            end else begin
               state_nx = ST_STOP;
            end
         end
         ST_WAIT_IDLE: begin
            if (tick_s && rx_s && (idle_cnt_r == IDX_LAST)) begin
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_WAIT_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Data bit counter. It is cleared during the start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_r <= 3'd0;
      end else if (state_r == ST_START) begin
         bit_cnt_r <= 3'd0;
      end else if (bit_inc_s) begin
         bit_cnt_r <= bit_cnt_r + 3'd1;
      end
   end

   // Shift register. Line order is LSB first, so each voted bit enters at the MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_r <= 8'h00;
      end else if (shift_en_s) begin
         shift_r <= {vote_s, shift_r[7:1]};
      end
   end

   // Consecutive-high tick counter used to recognise a full idle bit after an error or break.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_r <= '0;
      end else if ((state_r != ST_WAIT_IDLE) || !rx_s) begin
         idle_cnt_r <= '0;
      end else if (tick_s) begin
         idle_cnt_r <= idle_cnt_r + OS_W'(1);
      end
   end

   // Registered outputs: the data byte, the one-cycle strobes, the sticky error and the activity flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data_r   <= 8'h00;
         rx_ready_r  <= 1'b0;
         frame_err_r <= 1'b0;
         break_det_r <= 1'b0;
         rx_active_r <= 1'b0;
      end else begin
         rx_ready_r  <= load_s;
         break_det_r <= brk_s;
         rx_active_r <= (state_nx != ST_IDLE);
         if (load_s) begin
            rx_data_r   <= shift_r;
            frame_err_r <= 1'b0;
         end else if (ferr_s) begin
            frame_err_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Testbench for uart_rx_framer: directed serial frames with a scoreboard of expected bytes.
module tb_uart_rx_framer;

   localparam int BIT_CLK = 432;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_serial;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       frame_err;
   logic       break_det;
   logic       rx_active;

   int         chk_cnt   = 0;
   int         pass_cnt  = 0;
   int         ready_cnt = 0;
   int         brk_cnt   = 0;
   logic [7:0] exp_q[$];

   uart_rx_framer dut (
      .clk       (clk),
      .rst       (rst),
      .rx_serial (rx_serial),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .break_det (break_det),
      .rx_active (rx_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pop one expected byte for every rx_ready pulse, and count break pulses.
   always @(negedge clk) begin
      if (rx_ready || break_det) begin
         check("ready_break_exclusive", 32'(rx_ready & break_det), 32'd0);
      end
      if (break_det) begin
         brk_cnt++;
      end
      if (rx_ready) begin
         ready_cnt++;
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_rx_ready: got data 0x%0h expected no frame at %0t", rx_data, $time);
         end else begin
            check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input int bclk, input logic stop_bit);
      rx_serial = 1'b0;
      repeat (bclk) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_serial = d[i];
         repeat (bclk) @(negedge clk);
      end
      rx_serial = stop_bit;
      repeat (bclk) @(negedge clk);
      rx_serial = 1'b1;
   endtask

   task automatic wait_idle(input string name, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (!rx_active) break;
         @(negedge clk);
      end
      check(name, 32'(rx_active), 32'd0);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      rx_serial = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_rx_data",   32'(rx_data),   32'd0);
      check("reset_rx_ready",  32'(rx_ready),  32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_break_det", 32'(break_det), 32'd0);
      check("reset_rx_active", 32'(rx_active), 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Single nominal frame.
      exp_q.push_back(8'h41);
      send_byte(8'h41, BIT_CLK, 1'b1);
      check("t1_active_low_after_stop", 32'(rx_active), 32'd0);
      check("t1_frame_err", 32'(frame_err), 32'd0);
      check("t1_ready_cnt", 32'(ready_cnt), 32'd1);

      // Three back-to-back frames from a transmitter running 3% fast.
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hA5);
      send_byte(8'h00, 419, 1'b1);
      send_byte(8'hFF, 419, 1'b1);
      send_byte(8'hA5, 419, 1'b1);
      wait_idle("t2_idle", 1000);
      check("t2_ready_cnt", 32'(ready_cnt), 32'd4);
      check("t2_data", 32'(rx_data), 32'hA5);

      // A short low glitch is rejected as a false start.
      rx_serial = 1'b0;
      repeat (81) @(negedge clk);
      rx_serial = 1'b1;
      repeat (BIT_CLK - 81) @(negedge clk);
      check("t3_glitch_active", 32'(rx_active), 32'd0);
      check("t3_glitch_ferr", 32'(frame_err), 32'd0);
      check("t3_glitch_ready", 32'(ready_cnt), 32'd4);

      // A good frame, then a frame with a bad stop bit, then recovery.
      exp_q.push_back(8'h41);
      send_byte(8'h41, BIT_CLK, 1'b1);
      send_byte(8'h55, BIT_CLK, 1'b0);
      check("t4_active_wait_idle", 32'(rx_active), 32'd1);
      wait_idle("t4_idle", 1000);
      check("t4_frame_err", 32'(frame_err), 32'd1);
      check("t4_data_kept", 32'(rx_data), 32'h41);
      check("t4_no_break", 32'(brk_cnt), 32'd0);
      check("t4_ready_cnt", 32'(ready_cnt), 32'd5);
      exp_q.push_back(8'h12);
      send_byte(8'h12, BIT_CLK, 1'b1);
      wait_idle("t4b_idle", 1000);
      check("t4_frame_err_cleared", 32'(frame_err), 32'd0);
      check("t4_data_new", 32'(rx_data), 32'h12);

      // Break: the line is held low for 12 bit periods.
      rx_serial = 1'b0;
      repeat (12 * BIT_CLK) @(negedge clk);
      rx_serial = 1'b1;
      check("t5_break_cnt", 32'(brk_cnt), 32'd1);
      check("t5_frame_err", 32'(frame_err), 32'd1);
      check("t5_active_at_release", 32'(rx_active), 32'd1);
      repeat (380) @(negedge clk);
      check("t5_active_before_idle_bit", 32'(rx_active), 32'd1);
      wait_idle("t5_idle", 200);
      repeat (BIT_CLK) @(negedge clk);
      check("t5_break_once", 32'(brk_cnt), 32'd1);
      check("t5_no_spurious", 32'(ready_cnt), 32'd6);

      // Reset in the middle of a frame (after the 4th data bit of 0x3C).
      rx_serial = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_serial = (8'h3C >> i) & 8'h01;
         repeat (BIT_CLK) @(negedge clk);
      end
      check("t6_active_before_rst", 32'(rx_active), 32'd1);
      #2;
      rst       = 1'b1;
      rx_serial = 1'b1;
      #1;
      check("t6_rst_rx_data",   32'(rx_data),   32'd0);
      check("t6_rst_rx_ready",  32'(rx_ready),  32'd0);
      check("t6_rst_frame_err", 32'(frame_err), 32'd0);
      check("t6_rst_break_det", 32'(break_det), 32'd0);
      check("t6_rst_rx_active", 32'(rx_active), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, BIT_CLK, 1'b1);
      wait_idle("t6_idle", 1000);
      check("t6_data", 32'(rx_data), 32'h3C);
      check("t6_ready_cnt", 32'(ready_cnt), 32'd7);

      repeat (20) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
